cmp_result_collector: RTL and testbench
=======================================

// Module: cmp_result_collector
// PURPOSE
//  Downstream stage of the 4-bit domino comparator. Registers the comparator's evaluate-phase result
//  ('out', 1 = A==B) as a one-entry valid/ready output stage. Keeps saturating match/total counters,
//  a consecutive-match streak detector and a sticky mismatch flag for test/observability logic.
// PARAMETERS
//  CNT_W      8   width of match_cnt / total_cnt (saturating)
//  STREAK_TH  4   consecutive matches needed to assert streak_hit (1..2**CNT_W-1)
// PORTS
//  clk          in   1      single clock; comparator evaluates while clk=1, result sampled on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      cmp_out holds a settled evaluate-phase result this cycle
//  in_ready     out  1      stage can accept a result; = !out_valid | out_ready (combinational)
//  cmp_out      in   1      comparator 'out' (1 = equal, 0 = not equal)
//  clr          in   1      synchronous clear of counters, streak state and sticky flag (not of output reg)
//  out_valid    out  1      out_eq holds an unconsumed result
//  out_ready    in   1      consumer accepts out_eq this cycle
//  out_eq       out  1      registered comparison result
//  match_cnt    out  CNT_W  accepted results equal to 1, saturating
//  total_cnt    out  CNT_W  accepted results, saturating
//  streak_hit   out  1      high while in LOCK state
//  sticky_miss  out  1      set by any accepted 0; cleared only by clr or reset
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, out_eq=0, match_cnt=0, total_cnt=0, streak_hit=0,
//    sticky_miss=0, FSM=IDLE, streak count=0. Outputs leave reset on the first posedge after rst_n=1.
//  - Accept = in_valid & in_ready at posedge. On accept: out_eq<=cmp_out, out_valid<=1 (1-cycle latency).
//  - Handshake: out_valid & out_ready with no accept -> out_valid<=0. Accept and drain in same cycle
//    -> new value loaded, out_valid stays 1 (full throughput). While out_valid=1 & out_ready=0,
//    out_eq holds and in_ready=0; in_valid is ignored (not accepted, not counted).
//  - Counters advance only on accept: total_cnt+1; match_cnt+1 if cmp_out=1. Each saturates at
//    2**CNT_W-1 independently (no wrap).
//  - sticky_miss<=1 on accept with cmp_out=0.
//  - Streak FSM (internal count s, width CNT_W), updated only on accept:
//      IDLE: cmp_out=1 -> s=1, go RUN (or LOCK directly if STREAK_TH=1); cmp_out=0 -> stay, s=0.
//      RUN : cmp_out=1 -> s+1; if s+1==STREAK_TH go LOCK. cmp_out=0 -> s=0, go IDLE.
//      LOCK: cmp_out=1 -> stay (s not incremented). cmp_out=0 -> s=0, go IDLE.
//    streak_hit = (state==LOCK), registered, same cycle out_eq updates.
//  - clr=1: counters<=0, sticky_miss<=0, FSM<=IDLE, s<=0; an accept in the same cycle is still
//    loaded into out_eq/out_valid but is NOT counted, does not set sticky_miss, does not move FSM.
//  - Reset mid-transfer discards any pending out_eq; no X may propagate from cmp_out when in_valid=0.
// TESTING
//  T1 reset: rst_n=0 asynchronously mid-cycle with out_valid=1 -> all outputs 0 immediately.
//  T2 pairs A/B 1010/1010,1001/1010,1011/1100,1011/1011,1100/1010 (cmp_out 1,0,0,1,0), out_ready=1
//     -> out_eq 1,0,0,1,0 one cycle later; match_cnt=2, total_cnt=5, sticky_miss=1 after 2nd result.
//  T3 four consecutive equal pairs (1010/1010) -> streak_hit rises with 4th out_eq; one unequal
//     pair (1001/1010) -> streak_hit=0 next update.
//  T4 backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_eq held, counters
//     frozen; out_ready=1 -> one drain+accept per cycle, no result lost or duplicated.
//  T5 saturation with CNT_W=3: 10 equal results -> match_cnt=total_cnt=7, no wrap.
//  T6 clr asserted together with an accepted cmp_out=0 -> counters 0, sticky_miss 0, out_eq=0 valid.

Source files
------------

// File: rtl/cmp_result_collector_if.sv
// Handshake and observability bundle between the domino comparator, the result collector and its consumer.
// The master side drives results and consumer readiness. The slave (collector) side returns status.
interface cmp_result_collector_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             cmp_out;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic             out_eq;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] total_cnt;
  logic             streak_hit;
  logic             sticky_miss;

  modport master (
    output in_valid, cmp_out, clr, out_ready,
    input  in_ready, out_valid, out_eq, match_cnt, total_cnt, streak_hit, sticky_miss
  );

  modport slave (
    input  in_valid, cmp_out, clr, out_ready,
    output in_ready, out_valid, out_eq, match_cnt, total_cnt, streak_hit, sticky_miss
  );
endinterface

// File: rtl/cmp_result_collector.sv
// One-entry valid/ready output stage for the 4-bit domino comparator result, with saturating
// match/total counters, a consecutive-match streak FSM and a sticky mismatch flag.
module cmp_result_collector #(
  parameter int CNT_W     = 8,
  parameter int STREAK_TH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmp_result_collector_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TH  = CNT_W'(STREAK_TH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + ONE;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic             out_eq_q,    out_eq_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
  logic             sticky_q,    sticky_d;
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] streak_q,    streak_d;
  logic [CNT_W-1:0] streak_inc;

  logic in_ready;
  logic accept;
  logic count_en;
  logic streak_hit;

  // A result is taken when the stage is empty or being drained; clr suppresses bookkeeping only.
  always_comb begin
    in_ready = !out_valid_q | bus.out_ready;
    accept   = bus.in_valid & in_ready;
    count_en = accept & !bus.clr;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_eq_d    = out_eq_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_eq_d    = bus.cmp_out;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    match_cnt_d = match_cnt_q;
    total_cnt_d = total_cnt_q;
    sticky_d    = sticky_q;
    if (bus.clr) begin
      match_cnt_d = '0;
      total_cnt_d = '0;
      sticky_d    = 1'b0;
    end else if (count_en) begin
      total_cnt_d = sat_inc(total_cnt_q);
      if (bus.cmp_out) begin
        match_cnt_d = sat_inc(match_cnt_q);
      end else begin
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_eq_q    <= 1'b0;
      match_cnt_q <= '0;
      total_cnt_q <= '0;
      sticky_q    <= 1'b0;
      state_q     <= S_IDLE;
      streak_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_eq_q    <= out_eq_d;
      match_cnt_q <= match_cnt_d;
      total_cnt_q <= total_cnt_d;
      sticky_q    <= sticky_d;
      state_q     <= state_d;
      streak_q    <= streak_d;
    end
  end

  // Streak FSM: LOCK holds its count at the threshold instead of counting further.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    streak_inc = streak_q + ONE;
    if (bus.clr) begin
      state_d  = S_IDLE;
      streak_d = '0;
    end else if (count_en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmp_out) begin
            streak_d = ONE;
            state_d  = (TH == ONE) ? S_LOCK : S_RUN;
          end else begin
            streak_d = '0;
          end
        end
        S_RUN: begin
          if (bus.cmp_out) begin
            streak_d = streak_inc;
            if (streak_inc == TH) begin
              state_d = S_LOCK;
            end
          end else begin
            streak_d = '0;
            state_d  = S_IDLE;
          end
        end
        S_LOCK: begin
          if (!bus.cmp_out) begin
            streak_d = '0;
            state_d  = S_IDLE;
          end
        end
        default: begin
          streak_d = '0;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    streak_hit = (state_q == S_LOCK);
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_eq      = out_eq_q;
  assign bus.match_cnt   = match_cnt_q;
  assign bus.total_cnt   = total_cnt_q;
  assign bus.streak_hit  = streak_hit;
  assign bus.sticky_miss = sticky_q;

endmodule

// File: tb/tb_cmp_result_collector.sv
// Bench for cmp_result_collector: a wide instance (CNT_W=8, STREAK_TH=4) and a narrow one
// (CNT_W=3, STREAK_TH=1) share stimulus and are compared with a FIFO/arithmetic reference model.
module tb_cmp_result_collector;

  logic clk;
  logic rst_n;

  cmp_result_collector_if #(.CNT_W(8)) ifa ();
  cmp_result_collector_if #(.CNT_W(3)) ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.cmp_out   = ifa.cmp_out;
  assign ifb.clr       = ifa.clr;
  assign ifb.out_ready = ifa.out_ready;

  cmp_result_collector #(.CNT_W(8), .STREAK_TH(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  cmp_result_collector #(.CNT_W(3), .STREAK_TH(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the output stage is a one-entry FIFO of accepted results; the rest is arithmetic.
  bit exp_q[$];
  int m_tot;
  int m_match;
  int m_run;
  bit m_sticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_tot    = 0;
    m_match  = 0;
    m_run    = 0;
    m_sticky = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".a_ov"},  ifa.out_valid,   0);
    chk({tag, ".a_eq"},  ifa.out_eq,      0);
    chk({tag, ".a_mc"},  ifa.match_cnt,   0);
    chk({tag, ".a_tc"},  ifa.total_cnt,   0);
    chk({tag, ".a_hit"}, ifa.streak_hit,  0);
    chk({tag, ".a_stk"}, ifa.sticky_miss, 0);
    chk({tag, ".b_ov"},  ifb.out_valid,   0);
    chk({tag, ".b_mc"},  ifb.match_cnt,   0);
    chk({tag, ".b_tc"},  ifb.total_cnt,   0);
    chk({tag, ".b_hit"}, ifb.streak_hit,  0);
  endtask

  task automatic check_all(input string tag);
    logic ov;
    ov = (exp_q.size() != 0);
    chk({tag, ".a_ov"}, ifa.out_valid, ov);
    chk({tag, ".b_ov"}, ifb.out_valid, ov);
    if (ov) begin
      chk({tag, ".a_eq"}, ifa.out_eq, exp_q[0]);
      chk({tag, ".b_eq"}, ifb.out_eq, exp_q[0]);
    end
    chk({tag, ".a_mc"},  ifa.match_cnt,   sat(m_match, 255));
    chk({tag, ".a_tc"},  ifa.total_cnt,   sat(m_tot, 255));
    chk({tag, ".a_hit"}, ifa.streak_hit,  m_run >= 4);
    chk({tag, ".a_stk"}, ifa.sticky_miss, m_sticky);
    chk({tag, ".b_mc"},  ifb.match_cnt,   sat(m_match, 7));
    chk({tag, ".b_tc"},  ifb.total_cnt,   sat(m_tot, 7));
    chk({tag, ".b_hit"}, ifb.streak_hit,  m_run >= 1);
    chk({tag, ".b_stk"}, ifb.sticky_miss, m_sticky);
  endtask

  // Called just after a posedge; applies one cycle of stimulus and checks both sides of the next edge.
  task automatic step(input string tag, input logic v, input logic c, input logic r, input logic cl);
    bit rdy;
    bit acc;
    bit drn;
    ifa.in_valid  = v;
    ifa.cmp_out   = v ? c : 1'bx;
    ifa.out_ready = r;
    ifa.clr       = cl;
    #3;
    rdy = (exp_q.size() == 0) || r;
    acc = v && rdy;
    drn = (exp_q.size() != 0) && r;
    chk({tag, ".a_rdy"}, ifa.in_ready, rdy);
    chk({tag, ".b_rdy"}, ifb.in_ready, rdy);
    @(posedge clk);
    if (drn) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(c);
    if (cl) begin
      m_tot    = 0;
      m_match  = 0;
      m_run    = 0;
      m_sticky = 1'b0;
    end else if (acc) begin
      m_tot++;
      if (c) begin
        m_match++;
        m_run++;
      end else begin
        m_run    = 0;
        m_sticky = 1'b1;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic pair(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic r, input logic cl);
    step(tag, 1'b1, (a == b), r, cl);
  endtask

  logic [3:0] t2_a [5] = '{4'b1010, 4'b1001, 4'b1011, 4'b1011, 4'b1100};
  logic [3:0] t2_b [5] = '{4'b1010, 4'b1010, 4'b1100, 4'b1011, 4'b1010};

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    rst_n         = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.cmp_out   = 1'b0;
    ifa.out_ready = 1'b0;
    ifa.clr       = 1'b0;
    model_reset();
    #12;
    check_zero("rst_init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_exit");

    // T2: mixed equal/unequal pairs with a free-running consumer
    for (int i = 0; i < 5; i++) pair($sformatf("t2_%0d", i), t2_a[i], t2_b[i], 1'b1, 1'b0);
    chk("t2_mc_a", ifa.match_cnt, 2);
    chk("t2_tc_a", ifa.total_cnt, 5);
    chk("t2_stk",  ifa.sticky_miss, 1);

    // T3: four equal pairs lock the wide streak, one unequal pair drops it
    for (int i = 0; i < 4; i++) pair($sformatf("t3_eq%0d", i), 4'b1010, 4'b1010, 1'b1, 1'b0);
    chk("t3_hit_on", ifa.streak_hit, 1);
    pair("t3_ne", 4'b1001, 4'b1010, 1'b1, 1'b0);
    chk("t3_hit_off", ifa.streak_hit, 0);

    // T4: consumer stalls with a pending result, then drains one per cycle
    pair("t4_load", 4'b0110, 4'b0110, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pair($sformatf("t4_stall%0d", i), 4'b0001, 4'b0010, 1'b0, 1'b0);
    chk("t4_eq_held", ifa.out_eq, 1);
    for (int i = 0; i < 4; i++) pair($sformatf("t4_flow%0d", i), 4'(i), 4'(i % 2), 1'b1, 1'b0);
    step("t4_drain", 1'b0, 1'b0, 1'b1, 1'b0);
    step("t4_idle",  1'b0, 1'b0, 1'b0, 1'b0);

    // T1: asynchronous reset mid-cycle while a result is pending
    pair("t1_load", 4'b1111, 4'b1111, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t1_async");
    model_reset();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("t1_exit");

    // T5: ten equal results saturate the narrow counters at 7
    for (int i = 0; i < 10; i++) pair($sformatf("t5_%0d", i), 4'b0101, 4'b0101, 1'b1, 1'b0);
    chk("t5_mc_b", ifb.match_cnt, 7);
    chk("t5_tc_b", ifb.total_cnt, 7);
    chk("t5_tc_a", ifa.total_cnt, 10);

    // T6: clear coincides with an accepted mismatch
    pair("t6_pre", 4'b0011, 4'b0111, 1'b1, 1'b0);
    pair("t6_clr", 4'b0011, 4'b0111, 1'b1, 1'b1);
    chk("t6_tc",  ifa.total_cnt, 0);
    chk("t6_stk", ifa.sticky_miss, 0);
    chk("t6_ov",  ifa.out_valid, 1);
    chk("t6_eq",  ifa.out_eq, 0);

    // Randomized traffic: mixed validity, backpressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 1) == 1) ? ra : 4'($urandom_range(0, 15));
      step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0), (ra == rb),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
